hazard_scoreboard: RTL and testbench

- Parametrised successor to the per-operand Tuse decoders.
- Owns all stall and forward-source decisions for the D stage.
- Consumes per-source {addr, used, Tuse} and the D instruction's {dst, Tnew}.
- Holds a shift-register scoreboard of in-flight destinations for stages E..(E+DEPTH-1), plus a multiply/divide busy counter for HI/LO hazards. Drives the pipeline stall and per-source forward select.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/md_busy_counter.sv | 32 +++
 rtl/hazard_scoreboard.sv | 72 +++++++
 tb/tb_hazard_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the D-stage hazard scoreboard.
//   REG_AW       register address width
//   TNEW_W       width of Tuse/Tnew fields
//   FWD_*        forward-select encodings (0 = register file, k = stage k)
//   sb_entry_t   one in-flight destination slot {dst, tnew, md}
//   BUBBLE       empty slot; dst 0 never matches a source
//   sat_dec      Tnew countdown that stops at zero
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int TNEW_W = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [TNEW_W-1:0] tnew;
        logic              md;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE = '{dst: '0, tnew: '0, md: 1'b0};

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage operand/destination descriptors in, hazard
// decisions out.
//   D_srcAddr/D_srcUsed/D_srcTuse  per-source register, used flag, Tuse
//   D_dstAddr/D_dstTnew            D destination and its Tnew
//   D_mdStart/D_mdDiv/D_usesHILO   multiply/divide start and HI/LO use
//   stall, fwdSel, fwdReady, mdBusy  decisions back to the pipeline
// Handshake: there is no valid/ready pair; D inputs are sampled every cycle
// and stall is a same-cycle combinational hold request for the D stage.
// master = pipeline (drives D fields), slave = scoreboard.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] D_srcAddr;
    logic [NUM_SRC-1:0]        D_srcUsed;
    logic [NUM_SRC*TNEW_W-1:0] D_srcTuse;
    logic [REG_AW-1:0]         D_dstAddr;
    logic [TNEW_W-1:0]         D_dstTnew;
    logic                      D_mdStart;
    logic                      D_mdDiv;
    logic                      D_usesHILO;
    logic                      stall;
    logic [NUM_SRC*2-1:0]      fwdSel;
    logic [NUM_SRC-1:0]        fwdReady;
    logic                      mdBusy;

    modport master (
        output D_srcAddr, D_srcUsed, D_srcTuse, D_dstAddr, D_dstTnew,
               D_mdStart, D_mdDiv, D_usesHILO,
        input  stall, fwdSel, fwdReady, mdBusy
    );

    modport slave (
        input  D_srcAddr, D_srcUsed, D_srcTuse, D_dstAddr, D_dstTnew,
               D_mdStart, D_mdDiv, D_usesHILO,
        output stall, fwdSel, fwdReady, mdBusy
    );
endinterface

// File: rtl/md_busy_counter.sv
// md_busy_counter: HI/LO busy timer for the multiply/divide unit.
//   clk, reset  clock, async active-high reset
//   load        a mult/div enters E this edge
//   div         selects DIV_LAT instead of MULT_LAT on load
//   busy        counter nonzero
module md_busy_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic div,
    output logic busy
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall and forward-source decisions for the D stage.
//   clk, reset  clock, async active-high reset
//   hz          slave side of hazard_scoreboard_if
// Entry i of the shift register describes the instruction in stage E+i.
// Only the youngest matching entry counts; older writers of the same register
// are shadowed. DEPTH must lie in 1..3 since fwdSel is two bits per source.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave hz
);
    sb_entry_t          ent [DEPTH];
    logic [NUM_SRC-1:0] src_stall;
    logic               md_busy;
    logic               md_stall;
    logic               stall_int;

    // Youngest match wins: scan oldest to youngest so the last hit sticks.
    always_comb begin
        src_stall   = '0;
        hz.fwdSel   = '0;
        hz.fwdReady = '1;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (hz.D_srcUsed[j] &&
                    hz.D_srcAddr[REG_AW*j +: REG_AW] != '0 &&
                    ent[i].dst == hz.D_srcAddr[REG_AW*j +: REG_AW]) begin
                    hz.fwdSel[2*j +: 2] = 2'(i + 1);
                    hz.fwdReady[j]      = (ent[i].tnew == '0);
                    src_stall[j]        = (ent[i].tnew > hz.D_srcTuse[TNEW_W*j +: TNEW_W]);
                end
            end
        end
    end

    // entry[0].md covers the edge case where the counter view and the E slot
    // disagree; in practice busy is already set when a mult/div sits in E.
    assign md_stall  = hz.D_usesHILO & (md_busy | ent[0].md);
    assign stall_int = (|src_stall) | md_stall;
    assign hz.stall  = stall_int;
    assign hz.mdBusy = md_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= BUBBLE;
        end else begin
            ent[0] <= stall_int ? BUBBLE
                                : '{dst: hz.D_dstAddr, tnew: hz.D_dstTnew, md: hz.D_mdStart};
            for (int i = 1; i < DEPTH; i++) begin
                ent[i] <= '{dst: ent[i-1].dst, tnew: sat_dec(ent[i-1].tnew), md: 1'b0};
            end
        end
    end

    md_busy_counter #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md (
        .clk  (clk),
        .reset(reset),
        .load (hz.D_mdStart & ~stall_int),
        .div  (hz.D_mdDiv),
        .busy (md_busy)
    );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline sequences plus randomized traffic,
// checked against an issue-history model of the D-stage hazard rules.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 3;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int HIST     = 4096;

    typedef struct packed {
        logic [NUM_SRC*REG_AW-1:0] saddr;
        logic [NUM_SRC-1:0]        sused;
        logic [NUM_SRC*TNEW_W-1:0] stuse;
        logic [REG_AW-1:0]         dst;
        logic [TNEW_W-1:0]         tnew;
        logic                      md;
        logic                      div;
        logic                      hilo;
    } instr_t;

    logic clk;
    logic reset;

    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC)) hz ();

    hazard_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH),
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each cycle remembers what entered E (dst 0 for bubbles). The instruction
    // in stage E+i at cycle c was issued at cycle c-1-i, and its remaining
    // Tnew is its issue Tnew minus i, floored at zero.
    int unsigned        n_tests = 0;
    int unsigned        n_fail  = 0;
    int                 cyc     = 0;
    int                 base    = 0;
    logic [REG_AW-1:0]  iss_dst  [HIST];
    int                 iss_tnew [HIST];
    bit                 md_valid = 1'b0;
    int                 md_cyc   = 0;
    int                 md_lat   = 0;

    logic               exp_stall;
    logic [1:0]         exp_sel [NUM_SRC];
    logic               exp_rdy [NUM_SRC];
    logic               exp_busy;
    logic               last_stall;
    instr_t             cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_eval(input instr_t ins);
        logic any_src;
        any_src   = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            logic [REG_AW-1:0] a;
            int tuse;
            bit found;
            a      = ins.saddr[REG_AW*j +: REG_AW];
            tuse   = int'(ins.stuse[TNEW_W*j +: TNEW_W]);
            found  = 1'b0;
            exp_sel[j] = FWD_GRF;
            exp_rdy[j] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                int c;
                int rem;
                c = cyc - 1 - i;
                if (!found && c >= base && ins.sused[j] && a != 0 && iss_dst[c] == a) begin
                    found = 1'b1;
                    rem   = iss_tnew[c] - i;
                    if (rem < 0) rem = 0;
                    exp_sel[j] = 2'(i + 1);
                    exp_rdy[j] = (rem == 0);
                    if (rem > tuse) any_src = 1'b1;
                end
            end
        end
        exp_busy  = md_valid && (cyc - md_cyc) <= md_lat;
        exp_stall = any_src | (ins.hilo & exp_busy);
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "_stall"}, 32'(hz.stall), 32'(exp_stall));
        check({pfx, "_mdBusy"}, 32'(hz.mdBusy), 32'(exp_busy));
        for (int j = 0; j < NUM_SRC; j++) begin
            check($sformatf("%s_fwdSel%0d", pfx, j), 32'(hz.fwdSel[2*j +: 2]), 32'(exp_sel[j]));
            check($sformatf("%s_fwdReady%0d", pfx, j), 32'(hz.fwdReady[j]), 32'(exp_rdy[j]));
        end
    endtask

    task automatic record(input instr_t ins);
        if (exp_stall) begin
            iss_dst[cyc]  = '0;
            iss_tnew[cyc] = 0;
        end else begin
            iss_dst[cyc]  = ins.dst;
            iss_tnew[cyc] = int'(ins.tnew);
            if (ins.md) begin
                md_valid = 1'b1;
                md_cyc   = cyc;
                md_lat   = ins.div ? DIV_LAT : MULT_LAT;
            end
        end
        last_stall = exp_stall;
        cyc++;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input instr_t ins);
        cur           = ins;
        hz.D_srcAddr  = ins.saddr;
        hz.D_srcUsed  = ins.sused;
        hz.D_srcTuse  = ins.stuse;
        hz.D_dstAddr  = ins.dst;
        hz.D_dstTnew  = ins.tnew;
        hz.D_mdStart  = ins.md;
        hz.D_mdDiv    = ins.div;
        hz.D_usesHILO = ins.hilo;
    endtask

    task automatic step(input instr_t ins, input string pfx);
        @(negedge clk);
        drive(ins);
        #1;
        model_eval(ins);
        compare_all(pfx);
        record(ins);
    endtask

    // Hold the instruction in D until it is accepted.
    task automatic issue(input instr_t ins, input string pfx);
        int n;
        n = 0;
        do begin
            step(ins, pfx);
            n++;
        end while (last_stall && n < 40);
        if (last_stall) check({pfx, "_timeout"}, 32'd1, 32'd0);
    endtask

    function automatic instr_t mk(input logic [4:0] d, input logic [1:0] tn,
                                  input logic [4:0] s0, input logic [1:0] t0,
                                  input logic [4:0] s1, input logic [1:0] t1,
                                  input logic [1:0] used);
        instr_t r;
        r       = '0;
        r.dst   = d;
        r.tnew  = tn;
        r.saddr = {s1, s0};
        r.stuse = {t1, t0};
        r.sused = used;
        return r;
    endfunction

    function automatic instr_t mk_md(input logic div);
        instr_t r;
        r      = mk(5'd0, 2'd0, 5'd4, 2'd1, 5'd5, 2'd1, 2'b11);
        r.md   = 1'b1;
        r.div  = div;
        r.hilo = 1'b1;
        return r;
    endfunction

    function automatic instr_t mk_rand();
        instr_t r;
        r       = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            r.saddr[REG_AW*j +: REG_AW] = 5'($urandom_range(0, 7));
            r.stuse[TNEW_W*j +: TNEW_W] = 2'($urandom_range(0, 3));
        end
        r.sused = 2'($urandom_range(0, 3));
        r.dst   = 5'($urandom_range(0, 7));
        r.tnew  = 2'($urandom_range(0, 3));
        r.md    = ($urandom_range(0, 9) == 0);
        r.div   = 1'($urandom_range(0, 1));
        r.hilo  = r.md | ($urandom_range(0, 5) == 0);
        return r;
    endfunction

    instr_t nop;
    instr_t mflo;

    // ---------------- stimulus ----------------
    initial begin
        nop        = '0;
        mflo       = mk(5'd2, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
        mflo.hilo  = 1'b1;
        last_stall = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            iss_dst[i]  = '0;
            iss_tnew[i] = 0;
        end
        reset = 1'b1;
        drive(mk(5'd0, 2'd0, 5'd8, 2'd0, 5'd9, 2'd0, 2'b11));
        #2;
        check("rst_stall", 32'(hz.stall), 32'd0);
        check("rst_fwdSel", 32'(hz.fwdSel), 32'd0);
        check("rst_fwdReady", 32'(hz.fwdReady), 32'h3);
        check("rst_mdBusy", 32'(hz.mdBusy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // load-use, Tuse 1: one stall cycle then forward from M
        issue(mk(5'd8, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00), "lw");
        step(mk(5'd9, 2'd1, 5'd8, 2'd1, 5'd0, 2'd0, 2'b11), "lwuse1");
        check("lwuse1_first_stall", 32'(last_stall), 32'd1);
        issue(mk(5'd9, 2'd1, 5'd8, 2'd1, 5'd0, 2'd0, 2'b11), "lwuse1");
        check("lwuse1_fwd_M", 32'(hz.fwdSel[1:0]), 32'(FWD_M));
        repeat (3) step(nop, "nop");

        // load-branch, Tuse 0: forward from W after two stalls
        issue(mk(5'd8, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00), "lw2");
        issue(mk(5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd0, 2'b11), "beq");
        check("beq_fwd_W", 32'(hz.fwdSel[1:0]), 32'(FWD_W));
        repeat (3) step(nop, "nop");

        // $0 never matches; shadowed writers of $5
        issue(mk(5'd0, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00), "wr0");
        issue(mk(5'd3, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3, 2'b11), "rd0");
        check("rd0_fwd", 32'(hz.fwdSel), 32'd0);
        issue(mk(5'd5, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00), "wr5a");
        issue(mk(5'd5, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00), "wr5b");
        issue(mk(5'd6, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 2'b01), "rd5");
        check("rd5_fwd_E", 32'(hz.fwdSel[1:0]), 32'(FWD_E));
        repeat (3) step(nop, "nop");

        // mult then mflo
        issue(mk_md(1'b0), "mult");
        issue(mflo, "mflo");
        repeat (2) step(nop, "nop");

        // div, unrelated alu op, then mfhi waits out the rest
        issue(mk_md(1'b1), "div");
        issue(mk(5'd7, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1, 2'b11), "alu");
        repeat (3) step(nop, "nop");
        issue(mflo, "mfhi");
        repeat (2) step(nop, "nop");

        // reset during a load-use stall with the divider also busy
        issue(mk_md(1'b1), "div2");
        issue(mk(5'd8, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00), "lw3");
        step(mk(5'd9, 2'd1, 5'd8, 2'd0, 5'd0, 2'd0, 2'b01), "pre_rst");
        @(negedge clk);
        drive(mk(5'd9, 2'd1, 5'd8, 2'd0, 5'd0, 2'd0, 2'b01));
        #1;
        model_eval(cur);
        compare_all("pre_rst2");
        reset = 1'b1;
        #1;
        check("midrst_stall", 32'(hz.stall), 32'd0);
        check("midrst_mdBusy", 32'(hz.mdBusy), 32'd0);
        check("midrst_fwdSel", 32'(hz.fwdSel), 32'd0);
        reset    = 1'b0;
        base     = cyc;
        md_valid = 1'b0;
        #1;
        model_eval(cur);
        compare_all("post_rst");
        record(cur);
        repeat (3) step(nop, "nop");

        // randomized traffic; a stalled instruction stays in D
        begin
            instr_t r;
            r = mk_rand();
            for (int k = 0; k < 1500 && cyc < HIST - 8; k++) begin
                step(r, "rnd");
                if (!last_stall) r = mk_rand();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
